// File: rtl/rf_pkg.sv
// Shared definitions for the register file / scoreboard slice.
//  RF_DW     default register data width
//  RF_AW     default register index width (NREGS = 2**RF_AW)
//  rf_idx_t  register index at the default width
//  rf_data_t register data word at the default width
package rf_pkg;

  localparam int RF_DW = 16;
  localparam int RF_AW = 2;

  typedef logic [RF_AW-1:0] rf_idx_t;
  typedef logic [RF_DW-1:0] rf_data_t;

endpackage

// File: rtl/rf_sb_param_if.sv
// Bundle of the read, writeback and issue-side signals of the register file.
//  master : core side (drives indices, write and set requests; receives read data/status)
//  slave  : register file side
//  rn1/rn2        read indices          rd1/rd2            read data
//  rd1_busy/rd2_busy  in-flight producer flags for rn1/rn2
//  w/wn/wd        writeback request     set_en/set_idx     issue-side busy set
//  all_idle       no producer in flight err                sticky unexpected writeback
interface rf_sb_param_if
  import rf_pkg::*;
#(
  parameter int DW = RF_DW,
  parameter int AW = RF_AW
);

  logic [AW-1:0] rn1;
  logic [AW-1:0] rn2;
  logic [DW-1:0] rd1;
  logic [DW-1:0] rd2;
  logic          rd1_busy;
  logic          rd2_busy;
  logic          w;
  logic [AW-1:0] wn;
  logic [DW-1:0] wd;
  logic          set_en;
  logic [AW-1:0] set_idx;
  logic          all_idle;
  logic          err;

  modport master (
    output rn1, rn2, w, wn, wd, set_en, set_idx,
    input  rd1, rd2, rd1_busy, rd2_busy, all_idle, err
  );

  modport slave (
    input  rn1, rn2, w, wn, wd, set_en, set_idx,
    output rd1, rd2, rd1_busy, rd2_busy, all_idle, err
  );

endinterface

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: one bit per architectural register marking an in-flight producer.
//  clk, rst        clock / asynchronous active-high reset
//  w, wn           writeback clears busy[wn]
//  set_en, set_idx issue marks busy[set_idx]
//  busy            current busy vector (post-edge state)
//  all_idle        no busy bit set
//  err             sticky: writeback hit a register that was not busy
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int AW      = RF_AW,
  parameter int ZERO_R0 = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 w,
  input  logic [AW-1:0]        wn,
  input  logic                 set_en,
  input  logic [AW-1:0]        set_idx,
  output logic [(1<<AW)-1:0]   busy,
  output logic                 all_idle,
  output logic                 err
);

  localparam int NREGS = 1 << AW;

  logic [NREGS-1:0] busy_reg;
  logic [NREGS-1:0] busy_next;
  logic             err_reg;
  logic             err_next;
  logic             w_eff;
  logic             set_eff;

  // With a hard-wired r0, requests naming index 0 are dropped entirely.
  assign w_eff   = w      && !((ZERO_R0 != 0) && (wn == '0));
  assign set_eff = set_en && !((ZERO_R0 != 0) && (set_idx == '0));

  // Set beats clear on the same register: the set belongs to a newer producer.
  for (genvar gi = 0; gi < NREGS; gi++) begin : g_busy
    assign busy_next[gi] = (set_eff && (set_idx == AW'(gi))) ? 1'b1 :
                           (w_eff   && (wn      == AW'(gi))) ? 1'b0 :
                           busy_reg[gi];
  end

  // Error looks at the busy state before this edge's set/clear.
  assign err_next = err_reg | (w_eff & ~busy_reg[wn]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_reg <= '0;
      err_reg  <= 1'b0;
    end else begin
      busy_reg <= busy_next;
      err_reg  <= err_next;
    end
  end

  assign busy     = busy_reg;
  assign all_idle = ~|busy_reg;
  assign err      = err_reg;

endmodule

// File: rtl/rf_sb_param.sv
// 2-read / 1-write register file with integrated busy-bit scoreboard.
//  clk   clock, rising edge
//  rst   asynchronous active-high reset (clears storage, busy bits and err)
//  bus   slave side of rf_sb_param_if: read ports rn1/rn2 -> rd1/rd2 (+busy),
//        writeback w/wn/wd, issue set_en/set_idx, status all_idle/err
// Parameters: DW data width, AW index width, ZERO_R0 hard-wires r0 to zero,
// BYPASS forwards same-cycle write data to matching reads.
module rf_sb_param
  import rf_pkg::*;
#(
  parameter int DW      = RF_DW,
  parameter int AW      = RF_AW,
  parameter int ZERO_R0 = 0,
  parameter int BYPASS  = 1
) (
  input  logic          clk,
  input  logic          rst,
  rf_sb_param_if.slave  bus
);

  localparam int NREGS = 1 << AW;

  logic [DW-1:0]    regs_reg [NREGS];
  logic [NREGS-1:0] busy;
  logic             w_eff;
  logic [AW-1:0]    rn_arr    [2];
  logic [DW-1:0]    rd_arr    [2];
  logic             rbusy_arr [2];

  assign w_eff = bus.w && !((ZERO_R0 != 0) && (bus.wn == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_reg[i] <= '0;
      end
    end else if (w_eff) begin
      regs_reg[bus.wn] <= bus.wd;
    end
  end

  rf_scoreboard #(
    .AW      (AW),
    .ZERO_R0 (ZERO_R0)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .w        (bus.w),
    .wn       (bus.wn),
    .set_en   (bus.set_en),
    .set_idx  (bus.set_idx),
    .busy     (busy),
    .all_idle (bus.all_idle),
    .err      (bus.err)
  );

  assign rn_arr[0] = bus.rn1;
  assign rn_arr[1] = bus.rn2;

  // Read ports. A write held during reset is being discarded, so it is not
  // forwarded either. A forwarded value is available now, so busy reads 0.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    logic zero;
    logic hit;
    assign zero = (ZERO_R0 != 0) && (rn_arr[gi] == '0);
    assign hit  = (BYPASS != 0) && bus.w && !rst && (bus.wn == rn_arr[gi]);
    assign rd_arr[gi]    = zero ? '0 : (hit ? bus.wd : regs_reg[rn_arr[gi]]);
    assign rbusy_arr[gi] = !zero && !hit && busy[rn_arr[gi]];
  end

  assign bus.rd1      = rd_arr[0];
  assign bus.rd2      = rd_arr[1];
  assign bus.rd1_busy = rbusy_arr[0];
  assign bus.rd2_busy = rbusy_arr[1];

endmodule
